// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-ported memory bus between the IF stage
// (fetch, read-only) and the MEM stage (load/store).
//
// Handshake: a requester raises req (level) with stable address/data and
// holds it until its done pulse (one cycle, rdata valid in that cycle only).
// The bus side sees bus_req held high with stable bus_we/bus_addr/bus_wdata
// until the single-cycle bus_ack (bus_rdata valid with it), or until the
// timeout abort, which is flagged by a one-cycle bus_err.
//
// Optional feature macro: ARB_RR_EN -- when defined, ties between two
// eligible requesters alternate (the last granted side loses); when not
// defined, MEM always wins a tie.
//
// state_o exposes the arbiter state (0=IDLE, 1=GNT_IF, 2=GNT_MEM) for debug.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_done_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              bus_err_o,
    output logic [1:0]        state_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GNT_IF  = 2'd1;
    localparam logic [1:0] ST_GNT_MEM = 2'd2;

    // Counter only needs to reach TIMEOUT_CYC-1 (TIMEOUT_CYC >= 2).
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mask_if_q, mask_if_d;
    logic              mask_mem_q, mask_mem_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
`ifdef ARB_RR_EN
    logic              last_mem_q, last_mem_d;
`endif

    logic owner;
    logic ack_hit;
    logic tmo_hit;
    logic finish;
    logic elig_if;
    logic elig_mem;
    logic tie_to_mem;
    logic grant_if;
    logic grant_mem;

    // Transaction status and requester-facing outputs, all decoded from state.
    always_comb begin
        owner       = (state_q != ST_IDLE);
        ack_hit     = owner & bus_ack_i;
        // A same-cycle ack beats the timeout.
        tmo_hit     = owner & ~bus_ack_i & (cnt_q == CNT_LAST);
        finish      = ack_hit | tmo_hit;
        if_done_o   = (state_q == ST_GNT_IF) & finish;
        mem_done_o  = (state_q == ST_GNT_MEM) & finish;
        if_rdata_o  = ((state_q == ST_GNT_IF) & ack_hit) ? bus_rdata_i : '0;
        mem_rdata_o = ((state_q == ST_GNT_MEM) & ack_hit) ? bus_rdata_i : '0;
        stall_if_o  = if_req_i & ~if_done_o;
        stall_mem_o = mem_req_i & ~mem_done_o;
        bus_req_o   = owner;
        bus_err_o   = tmo_hit;
        bus_we_o    = bus_we_q;
        bus_addr_o  = bus_addr_q;
        bus_wdata_o = bus_wdata_q;
        state_o     = state_q;
        // A requester served on the previous edge is ignored for one cycle.
        elig_if     = if_req_i & ~mask_if_q;
        elig_mem    = mem_req_i & ~mask_mem_q;
`ifdef ARB_RR_EN
        tie_to_mem  = ~last_mem_q;
`else
        tie_to_mem  = 1'b1;
`endif
    end

    // Next-state: arbitration in IDLE, completion/timeout in owner states.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_if_d   = 1'b0;
        mask_mem_d  = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        grant_if    = 1'b0;
        grant_mem   = 1'b0;
`ifdef ARB_RR_EN
        last_mem_d  = last_mem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig_if && elig_mem) begin
                    grant_mem = tie_to_mem;
                    grant_if  = ~tie_to_mem;
                end else begin
                    grant_mem = elig_mem;
                    grant_if  = elig_if;
                end
            end
            ST_GNT_IF: begin
                if (finish) begin
                    mask_if_d = 1'b1;
                    if (ack_hit && elig_mem) grant_mem = 1'b1;
                    else                     state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GNT_MEM: begin
                if (finish) begin
                    mask_mem_d = 1'b1;
                    if (ack_hit && elig_if) grant_if = 1'b1;
                    else                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_mem) begin
            state_d     = ST_GNT_MEM;
            cnt_d       = '0;
            bus_we_d    = mem_we_i;
            bus_addr_d  = mem_addr_i;
            bus_wdata_d = mem_wdata_i;
`ifdef ARB_RR_EN
            last_mem_d  = 1'b1;
`endif
        end else if (grant_if) begin
            state_d     = ST_GNT_IF;
            cnt_d       = '0;
            bus_we_d    = 1'b0;
            bus_addr_d  = if_addr_i;
            bus_wdata_d = '0;
`ifdef ARB_RR_EN
            last_mem_d  = 1'b0;
`endif
        end
    end

    // State and latched bus registers; reset drops bus_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mask_if_q   <= 1'b0;
            mask_mem_q  <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_if_q   <= mask_if_d;
            mask_mem_q  <= mask_mem_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant memory for tie alternation; starts as IF so MEM wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_mem_q <= 1'b0;
        else        last_mem_q <= last_mem_d;
    end
`endif

endmodule
